// File: rtl/ov_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov_pkg
// Description : Shared constants for the OV sensor configuration sequencer.
//               Holds the FSM state encoding and the table entry tags.
// Revision    : 1.0 - initial release
// ============================================================================
package ov_pkg;

  // Sequencer states, 3-bit encoded
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PWR_WAIT = 3'd1;
  localparam logic [2:0] ST_FETCH    = 3'd2;
  localparam logic [2:0] ST_DECODE   = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_DELAY    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  // Table entry tags
  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [7:0]  DLY_TAG  = 8'hF0;

  // Timing
  localparam int US_PER_MS = 1000;
  localparam int MS_W      = 16;

  // True for a delay entry (upper byte F0); the end marker never matches
  function automatic logic is_delay(input logic [15:0] entry);
    return (entry[15:8] == DLY_TAG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov_cfg_seq_tick.sv
`default_nettype none
// ============================================================================
// Module      : ov_cfg_tick
// Description : Millisecond countdown built from the 1 us tick. Load sets the
//               number of ms to wait; expire is high once it has elapsed.
//               The ms counter stops at zero instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module ov_cfg_tick
  import ov_pkg::*;
(
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            pluse_us,
  input  logic            load,
  input  logic [MS_W-1:0] load_ms,
  output logic            expire
);

  localparam int              US_W      = $clog2(US_PER_MS);
  localparam logic [US_W-1:0] c_us_last = US_W'(US_PER_MS - 1);

  logic [US_W-1:0] r_us_cnt;
  logic [MS_W-1:0] r_ms_left;

  // Count us ticks within the current ms and retire one ms every 1000 ticks
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_us_cnt  <= '0;
      r_ms_left <= '0;
    end else if (load) begin
      r_us_cnt  <= '0;
      r_ms_left <= load_ms;
    end else if (pluse_us && (r_ms_left != '0)) begin
      if (r_us_cnt == c_us_last) begin
        r_us_cnt  <= '0;
        r_ms_left <= r_ms_left - MS_W'(1);
      end else begin
        r_us_cnt  <= r_us_cnt + US_W'(1);
      end
    end
  end

  assign expire = (r_ms_left == '0);

endmodule
`default_nettype wire

// File: rtl/ov_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : ov_cfg_seq
// Description : Walks an external register table and issues SCCB writes to
//               an OV image sensor. Entries: FFFF ends the table, F0nn waits
//               nn ms, anything else is a {reg, val} write.
//               Build option OV_CFG_RETRY_EN: retry a nacked write up to
//               RETRY_MAX times before giving up.
// Revision    : 1.0 - initial release
// ============================================================================
module ov_cfg_seq
  import ov_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         PWR_WAIT_MS = 10,
  parameter int         ROM_AW      = 8,
  parameter int         RETRY_MAX   = 3
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              pluse_us,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              iic_req,
  output logic [7:0]        iic_dev,
  output logic [7:0]        iic_reg,
  output logic [7:0]        iic_val,
  input  logic              iic_ack,
  input  logic              iic_nack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROM_AW-1:0] wr_cnt
);

  logic [2:0]        r_state;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [ROM_AW-1:0] r_wr_cnt;
  logic [7:0]        r_dev;
  logic [7:0]        r_reg;
  logic [7:0]        r_val;

  logic              w_start_ok;
  logic              w_last_entry;
  logic              w_dly_entry;
  logic              w_may_retry;
  logic              w_tick_load;
  logic [MS_W-1:0]   w_tick_ms;
  logic              w_tick_expire;

  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));
  assign w_last_entry = (r_rom_addr == {ROM_AW{1'b1}});
  assign w_dly_entry  = (rom_data != END_MARK) && is_delay(rom_data);

  // The countdown is shared: power-up settle on start, table delays in DECODE
  assign w_tick_load = w_start_ok || ((r_state == ST_DECODE) && w_dly_entry);
  assign w_tick_ms   = w_start_ok ? MS_W'(PWR_WAIT_MS)
                                  : {{(MS_W-8){1'b0}}, rom_data[7:0]};

  ov_cfg_tick u_tick (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .load     (w_tick_load),
    .load_ms  (w_tick_ms),
    .expire   (w_tick_expire)
  );

`ifdef OV_CFG_RETRY_EN
  localparam int RC_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RC_W-1:0] r_retry;

  assign w_may_retry = (r_retry < RC_W'(RETRY_MAX));

  // Retries spent on the current entry; a fresh entry or run starts at zero
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (w_start_ok) begin
      r_retry <= '0;
    end else if (r_state == ST_WRITE) begin
      if (iic_nack) begin
        if (w_may_retry) begin
          r_retry <= r_retry + RC_W'(1);
        end
      end else if (iic_ack) begin
        r_retry <= '0;
      end
    end
  end
`else
  // Never true: without retries the first nack ends the run
  assign w_may_retry = (RETRY_MAX < 0);
`endif

  // Main sequencer: fetch, decode and execute one table entry at a time
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rom_addr <= '0;
      r_wr_cnt   <= '0;
      r_dev      <= '0;
      r_reg      <= '0;
      r_val      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state    <= ST_PWR_WAIT;
            r_rom_addr <= '0;
            r_wr_cnt   <= '0;
          end
        end
        ST_PWR_WAIT: begin
          if (w_tick_expire) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // rom_data for the new address lands at the end of this cycle
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (rom_data == END_MARK) begin
            r_state <= ST_DONE;
          end else if (w_dly_entry) begin
            r_state <= ST_DELAY;
          end else begin
            r_state <= ST_WRITE;
            r_dev   <= DEV_ADDR;
            r_reg   <= rom_data[15:8];
            r_val   <= rom_data[7:0];
          end
        end
        ST_WRITE: begin
          // nack wins when both responses arrive together; a retry goes back
          // through DECODE so the request drops for one cycle between tries
          if (iic_nack) begin
            r_state <= w_may_retry ? ST_DECODE : ST_ERR;
          end else if (iic_ack) begin
            r_wr_cnt <= r_wr_cnt + ROM_AW'(1);
            if (w_last_entry) begin
              r_state <= ST_ERR;
            end else begin
              r_rom_addr <= r_rom_addr + ROM_AW'(1);
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (w_tick_expire) begin
            if (w_last_entry) begin
              r_state <= ST_ERR;
            end else begin
              r_rom_addr <= r_rom_addr + ROM_AW'(1);
              r_state    <= ST_FETCH;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = r_rom_addr;
  assign wr_cnt   = r_wr_cnt;
  assign iic_dev  = r_dev;
  assign iic_reg  = r_reg;
  assign iic_val  = r_val;
  assign iic_req  = (r_state == ST_WRITE);
  assign done     = (r_state == ST_DONE);
  assign err      = (r_state == ST_ERR);
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);

endmodule
`default_nettype wire

// File: doc/ov_cfg_seq.md
OV_CFG_SEQ -- requirements
Module: ov_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h42, SCCB write address of the OV sensor.
REQ-002 Parameter PWR_WAIT_MS, default 10, settle time in ms after start before the first write.
REQ-003 Parameter ROM_AW, default 8, table address width.
REQ-004 Parameter RETRY_MAX, default 3, NACK retries per entry.
REQ-005 clk_sys  in  1  system clock, the only clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 pluse_us  in  1  one-cycle tick every 1 us.
REQ-008 start  in  1  level/pulse request to run the table; sampled only in IDLE, DONE or ERR.
REQ-009 rom_addr  out  ROM_AW  table address.
REQ-010 rom_data  in  16  {reg[15:8], val[7:0]}, valid one cycle after rom_addr changes.
REQ-011 iic_req  out  1  write request to the SCCB master; held until iic_ack or iic_nack.
REQ-012 iic_dev / iic_reg / iic_val  out  8/8/8  device address, register and value; stable while iic_req=1.
REQ-013 iic_ack  in  1  one-cycle pulse: write completed, acknowledged.
REQ-014 iic_nack  in  1  one-cycle pulse: write completed, not acknowledged.
REQ-015 busy / done / err  out  1/1/1  status; done and err are levels, cleared by the next start.
REQ-016 wr_cnt  out  ROM_AW  number of writes acknowledged in the current run.

Function
REQ-017 States are IDLE, PWR_WAIT, FETCH, DECODE, WRITE, DELAY, DONE and ERR, encoded 3-bit in the shared package.
REQ-018 A start in IDLE, DONE or ERR moves to PWR_WAIT, clears done, err and wr_cnt, sets rom_addr=0 and asserts busy.
REQ-019 PWR_WAIT counts PWR_WAIT_MS*1000 pluse_us ticks, then goes to FETCH.
REQ-020 FETCH waits exactly one cycle for rom_data, then goes to DECODE.
REQ-021 In DECODE, entry 16'hFFFF moves to DONE.
REQ-022 In DECODE, entry 16'hF0nn moves to DELAY for nn ms (nn=0 means 0 ms; DELAY exits on the next cycle); rom_addr then increments.
REQ-023 In DECODE, any other entry moves to WRITE with iic_reg=rom_data[15:8], iic_val=rom_data[7:0] and iic_dev=DEV_ADDR.
REQ-024 WRITE asserts iic_req on the cycle it is entered and deasserts it in the same cycle that iic_ack or iic_nack is sampled.
REQ-025 On iic_ack, wr_cnt and rom_addr increment and the state moves to FETCH.
REQ-026 If iic_ack and iic_nack are both high in one cycle, the block treats it as a nack.
REQ-027 The ms counter counts 1000 pluse_us ticks per ms and saturates rather than wraps.
REQ-028 When rom_addr reaches 2^ROM_AW-1 without finding the end marker, the block moves to ERR after that entry completes.
REQ-029 DONE and ERR deassert busy and hold their status until the next start.
REQ-030 A start while busy is ignored.
REQ-031 iic_ack and iic_nack are ignored outside WRITE.

Reset
REQ-032 rst_n low forces IDLE asynchronously.
REQ-033 While rst_n is low, all outputs are 0: rom_addr, iic_req, iic_dev, iic_reg, iic_val, busy, done, err and wr_cnt.
REQ-034 A reset during WRITE drops iic_req immediately; the run does not resume.

Configuration
REQ-035 With OV_CFG_RETRY_EN defined, a nack re-enters WRITE for the same entry up to RETRY_MAX times; the retry counter is cleared on ack.
REQ-036 With OV_CFG_RETRY_EN defined, the next nack after RETRY_MAX retries moves to ERR.
REQ-037 Without OV_CFG_RETRY_EN, the first nack moves to ERR and no retry counter exists.

Structure
REQ-038 Package ov_pkg holds the state encoding, END_MARK=16'hFFFF, DLY_TAG=8'hF0 and US_PER_MS=1000.
REQ-039 Sub-module ov_cfg_tick turns pluse_us into a ms-tick counter with load and expire and is used by PWR_WAIT and DELAY.
REQ-040 The table ROM sits outside this block.

Verification
REQ-041 Reset then start, PWR_WAIT_MS=1, ROM {1280,1100,FFFF}, always ack -> two iic_req with reg/val 12/80 and 11/00; done=1 and wr_cnt=2, first iic_req 1000 ticks after start.
REQ-042 ROM {F005,1280,FFFF} -> iic_req for 12/80 rises no earlier than 5000 pluse_us ticks after DELAY is entered.
REQ-043 RETRY_EN build, RETRY_MAX=3, entry 1280 nacked twice then acked -> three requests for the same entry, done=1, err=0.
REQ-044 Non-RETRY build, first entry nacked -> err=1, busy=0, wr_cnt=0, no further iic_req.
REQ-045 rst_n pulsed low mid-WRITE -> iic_req=0 the same cycle, state IDLE, status cleared; a new start replays from entry 0.
REQ-046 ROM_AW=2 with no FFFF entry, all acked -> 4 writes, then err=1.
